systolic_stream_port: RTL and testbench

Byte-stream front/back end for the 2x2-output systolic convolution array: it receives a serial frame of filter and image bytes, presents them to the array as parallel buses, holds the array in reset while loading, and releases it for a fixed compute window. It then captures the four 8-bit results and returns them as a serial byte stream. It replaces the parallel, bench-driven stimulus of the array with a valid/ready transport usable by a host link.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/systolic_out_serializer.sv | 61 ++++++
 rtl/systolic_stream_port.sv | 118 +++++++++++
 tb/tb_systolic_stream_port.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array stream port.
package systolic_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  localparam int FLT_BYTES   = 9;
  localparam int IMG_BYTES   = 16;
  localparam int RES_BYTES   = 4;
  localparam int FRAME_BYTES = FLT_BYTES + IMG_BYTES;

  localparam int IMG_W = 8 * IMG_BYTES;
  localparam int FLT_W = 8 * FLT_BYTES;
  localparam int RES_W = 8 * RES_BYTES;
  localparam int IDX_W = 5;

endpackage

// File: rtl/systolic_out_serializer.sv
// Captures the four array results and streams them out o00..o11.
module systolic_out_serializer
  import systolic_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_i,
  input  logic [RES_W-1:0] res_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [7:0]       out_data_o,
  output logic             done_o
);

  logic [RES_W-1:0] res_q, res_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             vld_q, vld_d;
  logic             hs;

  always_comb begin
    res_d = res_q;
    ptr_d = ptr_q;
    vld_d = vld_q;
    hs    = vld_q && out_ready_i;
    if (cap_i) begin
      res_d = res_i;
      ptr_d = 2'd0;
      vld_d = 1'b1;
    end else if (hs) begin
      ptr_d = ptr_q + 2'd1;
      if (ptr_q == 2'd3) vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      ptr_q <= '0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      ptr_q <= ptr_d;
      vld_q <= vld_d;
    end
  end

  always_comb begin
    out_data_o = res_q[31:24];
    unique case (ptr_q)
      2'd0: out_data_o = res_q[31:24];
      2'd1: out_data_o = res_q[23:16];
      2'd2: out_data_o = res_q[15:8];
      2'd3: out_data_o = res_q[7:0];
      default: out_data_o = res_q[31:24];
    endcase
  end

  assign out_valid_o = vld_q;
  assign done_o      = hs && (ptr_q == 2'd3);

endmodule

// File: rtl/systolic_stream_port.sv
// Serial byte front/back end for the 2x2 systolic convolution array.
// Optional SYSTOLIC_STREAM_FLT_KEEP_EN: image-only frames keep the filter.
module systolic_stream_port
  import systolic_pkg::*;
#(
  parameter int COMPUTE_CYCLES = 70
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             flt_load,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             arr_rst,
  output logic [IMG_W-1:0] img,
  output logic [FLT_W-1:0] flt,
  input  logic [RES_W-1:0] res
);

  localparam logic [7:0]       CNT_LAST = 8'(COMPUTE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_FLT  = IDX_W'(FLT_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IMG_W-1:0] img_q, img_d;
  logic [FLT_W-1:0] flt_q, flt_d;
  logic             cap;
  logic             done;
  logic             img_only;

`ifdef SYSTOLIC_STREAM_FLT_KEEP_EN
  assign img_only = (idx_q == '0) && !flt_load;
`else
  logic unused_flt_load;
  assign unused_flt_load = flt_load;
  assign img_only        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    img_d   = img_q;
    flt_d   = flt_q;
    cap     = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          idx_d = idx_q + 1'b1;
          if (img_only) begin
            // Image-only frame: skip the filter slots entirely
            img_d = {img_q[IMG_W-9:0], in_data};
            idx_d = IDX_FLT + 1'b1;
          end else if (idx_q < IDX_FLT) begin
            flt_d = {flt_q[FLT_W-9:0], in_data};
          end else begin
            img_d = {img_q[IMG_W-9:0], in_data};
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              cnt_d   = '0;
              state_d = COMPUTE;
            end
          end
        end
      end
      COMPUTE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          cap     = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (done) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      img_q   <= '0;
      flt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      img_q   <= img_d;
      flt_q   <= flt_d;
    end
  end

  systolic_out_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .cap_i      (cap),
    .res_i      (res),
    .out_ready_i(out_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .done_o     (done)
  );

  assign in_ready = (state_q == LOAD);
  assign arr_rst  = (state_q != COMPUTE);
  assign img      = img_q;
  assign flt      = flt_q;

endmodule

// File: tb/tb_systolic_stream_port.sv
// Directed bench for systolic_stream_port with a behavioural 2x2 array.
module tb_systolic_stream_port;

  localparam int CC = 70;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         flt_load;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         arr_rst;
  logic [127:0] img;
  logic [71:0]  flt;
  logic [31:0]  res;

  always #5 clk = ~clk;

  systolic_stream_port #(.COMPUTE_CYCLES(CC)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flt_load (flt_load),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .arr_rst  (arr_rst),
    .img      (img),
    .flt      (flt),
    .res      (res)
  );

  function automatic logic [31:0] conv(logic [127:0] im, logic [71:0] f);
    logic [31:0] r;
    logic [7:0]  acc;
    int          p, q;
    r = '0;
    for (int oy = 0; oy < 2; oy++) begin
      for (int ox = 0; ox < 2; ox++) begin
        acc = '0;
        for (int ky = 0; ky < 3; ky++) begin
          for (int kx = 0; kx < 3; kx++) begin
            p   = (oy + ky) * 4 + ox + kx;
            q   = ky * 3 + kx;
            acc = acc + 8'(im[127-8*p -: 8] * f[71-8*q -: 8]);
          end
        end
        r[31-8*(oy*2+ox) -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Array model: results appear only after it has run a few cycles
  int arr_cnt;
  always @(posedge clk) begin
    if (arr_rst) arr_cnt <= 0;
    else         arr_cnt <= arr_cnt + 1;
  end
  assign res = (arr_cnt >= 5) ? conv(img, flt) : 32'h0;

  typedef struct {
    logic [71:0]  f;
    logic [127:0] im;
    logic [31:0]  ex;
    int           gap;
    int           stall;
  } vec_t;

  vec_t vecs[4];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(vec_t v, int nb, int i);
    logic [71:0]  f;
    logic [127:0] im;
    f  = v.f;
    im = v.im;
    if (nb == 16)  return im[127-8*i -: 8];
    if (i < 9)     return f[71-8*i -: 8];
    return im[127-8*(i-9) -: 8];
  endfunction

  task automatic send_frame(vec_t v, bit fl, int nb);
    for (int i = 0; i < nb; i++) begin
      if (i == v.gap) begin
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = frame_byte(v, nb, i);
      flt_load = fl;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(vec_t v, bit fl, int nb);
    int k;
    bit idle_bad;
    bit stall_bad;
    logic [31:0] ex;
    ex = v.ex;
    send_frame(v, fl, nb);
    chk("arr_rst_fall", 128'(arr_rst), 128'(0));
    chk("in_ready_low", 128'(in_ready), 128'(0));
    chk("img_loaded", img, v.im);
    chk("flt_loaded", 128'(flt), 128'(v.f));
    k = 0;
    idle_bad = 1'b0;
    while (!out_valid && k < 300) begin
      in_valid = k[0];
      in_data  = 8'hEE;
      if (in_ready !== 1'b0 || arr_rst !== 1'b0) idle_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    chk("first_valid_lat", 128'(k + 1), 128'(CC + 1));
    chk("compute_idle", 128'(idle_bad), 128'(0));
    chk("drain_arr_rst", 128'(arr_rst), 128'(1));
    chk("img_hold", img, v.im);
    stall_bad = 1'b0;
    out_ready = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      if (out_valid !== 1'b1 || out_data !== ex[31:24]) stall_bad = 1'b1;
      @(negedge clk);
    end
    if (v.stall > 0) chk("stall_hold", 128'(stall_bad), 128'(0));
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("out_byte", 128'({out_valid, out_data}), 128'({1'b1, ex[31-8*j -: 8]}));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("in_ready_back", 128'(in_ready), 128'(1));
    chk("out_valid_done", 128'(out_valid), 128'(0));
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_arr_rst", 128'(arr_rst), 128'(1));
    chk("rst_img", img, 128'(0));
    chk("rst_flt", 128'(flt), 128'(0));
  endtask

  initial begin
    int k;
    vecs[0] = '{72'h01_05_08_06_00_07_03_01_02,
                128'h08_03_09_01_07_07_02_08_05_06_03_01_04_09_02_06,
                32'hB2_B1_86_A5, -1, 0};
    vecs[1] = '{72'h01_05_08_06_00_07_03_01_02,
                128'h08_03_09_01_07_07_02_08_05_06_03_01_04_09_02_06,
                32'hB2_B1_86_A5, 12, 10};
    vecs[2] = '{72'h01_01_01_01_01_01_01_01_01,
                128'h01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10,
                32'h36_3F_5A_63, -1, 0};
    vecs[3] = '{{9{8'hFF}}, {16{8'hFF}}, 32'h09_09_09_09, 20, 2};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    flt_load  = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_frame(vecs[i], 1'b1, 25);

    // Reset after 12 bytes of a frame
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = frame_byte(vecs[2], 25, i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    run_frame(vecs[0], 1'b1, 25);

    // Reset while results are waiting in the drain
    send_frame(vecs[2], 1'b1, 25);
    k = 0;
    while (!out_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain_reached", 128'(out_valid), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    run_frame(vecs[0], 1'b1, 25);

`ifdef SYSTOLIC_STREAM_FLT_KEEP_EN
    run_frame(vecs[0], 1'b1, 25);
    run_frame(vecs[0], 1'b0, 16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
